// File: rtl/pe_param.sv
// Parametrised weight-stationary / output-stationary systolic PE with double-buffered weights and stall.
// Define PE_SATURATE_EN for saturating arithmetic and a sticky overflow flag (wraps otherwise).
module pe_param #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pe_enabled,
    input  logic                  mode_os,
    input  logic [DATA_WIDTH-1:0] pe_psum_in,
    input  logic [DATA_WIDTH-1:0] pe_weight_in,
    input  logic                  pe_accept_w_in,
    input  logic [DATA_WIDTH-1:0] pe_input_in,
    input  logic                  pe_valid_in,
    input  logic                  pe_switch_in,
    input  logic                  pe_drain_in,
    input  logic                  clear_ovf,
    output logic [DATA_WIDTH-1:0] pe_psum_out,
    output logic                  pe_psum_valid_out,
    output logic [DATA_WIDTH-1:0] pe_weight_out,
    output logic                  pe_accept_w_out,
    output logic [DATA_WIDTH-1:0] pe_input_out,
    output logic                  pe_valid_out,
    output logic                  pe_switch_out,
    output logic                  pe_drain_out,
    output logic                  overflow_out
);

    localparam int PW = 2 * DATA_WIDTH;
`ifdef PE_SATURATE_EN
    localparam logic [DATA_WIDTH-1:0] D_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] D_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [PW-1:0] PROD_MAX = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] PROD_MIN = {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        ST_WS       = 2'd0,
        ST_OS_ACC   = 2'd1,
        ST_OS_DRAIN = 2'd2
    } state_t;

    // Both reducers return {clamped, value}; the clamp bit is always 0 in wrap builds.
    function automatic logic [DATA_WIDTH:0] reduce_prod(input logic signed [PW-1:0] prod);
        logic signed [PW-1:0] shifted;
        logic [DATA_WIDTH:0]  res;
        shifted = prod >>> FRAC_BITS;
        res     = {1'b0, DATA_WIDTH'(shifted)};
`ifdef PE_SATURATE_EN
        if (shifted > PROD_MAX)      res = {1'b1, D_MAX};
        else if (shifted < PROD_MIN) res = {1'b1, D_MIN};
`endif
        return res;
    endfunction

    function automatic logic [DATA_WIDTH:0] reduce_sum(input logic signed [DATA_WIDTH:0] sum);
        logic [DATA_WIDTH:0] res;
        res = {1'b0, DATA_WIDTH'(sum)};
`ifdef PE_SATURATE_EN
        if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])
            res = {1'b1, (sum[DATA_WIDTH] ? D_MIN : D_MAX)};
`endif
        return res;
    endfunction

    state_t                        state_q, state_d;
    logic signed [DATA_WIDTH-1:0]  acc_q, acc_d;
    logic                          acc_pending_q, acc_pending_d;
    logic signed [DATA_WIDTH-1:0]  w_active_q, w_active_d;
    logic signed [DATA_WIDTH-1:0]  w_inactive_q, w_inactive_d;
    logic [DATA_WIDTH-1:0]         psum_q, psum_d;
    logic                          psum_valid_q, psum_valid_d;
    logic [DATA_WIDTH-1:0]         weight_fwd_q, weight_fwd_d;
    logic                          accept_fwd_q, accept_fwd_d;
    logic [DATA_WIDTH-1:0]         input_fwd_q, input_fwd_d;
    logic                          valid_fwd_q, valid_fwd_d;
    logic                          switch_fwd_q, switch_fwd_d;
    logic                          drain_fwd_q, drain_fwd_d;
    logic                          ovf_q, ovf_d;

    logic                          is_os, do_mac, sat_evt;
    logic signed [DATA_WIDTH-1:0]  w_sel, mac_a, mac_w, addend;
    logic signed [PW-1:0]          prod_full;
    logic [DATA_WIDTH:0]           prod_r, sum_r;
    logic signed [DATA_WIDTH:0]    sum_wide;

    // Single shared MAC: WS adds the north psum, OS adds the local accumulator.
    always_comb begin
        is_os     = (state_q != ST_WS);
        w_sel     = pe_switch_in ? w_inactive_q : w_active_q;
        mac_a     = $signed(pe_input_in);
        mac_w     = is_os ? $signed(pe_weight_in) : w_sel;
        addend    = is_os ? acc_q : $signed(pe_psum_in);
        do_mac    = pe_valid_in & (~is_os | pe_accept_w_in);
        prod_full = mac_a * mac_w;
        prod_r    = reduce_prod(prod_full);
        sum_wide  = {addend[DATA_WIDTH-1], addend} + {prod_r[DATA_WIDTH-1], prod_r[DATA_WIDTH-1:0]};
        sum_r     = reduce_sum(sum_wide);
        sat_evt   = do_mac & (prod_r[DATA_WIDTH] | sum_r[DATA_WIDTH]);
    end

    // Mode changes only take effect on an idle cycle with nothing left to drain.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WS: begin
                if (!pe_valid_in && !acc_pending_q && mode_os) state_d = ST_OS_ACC;
            end
            ST_OS_ACC: begin
                if (pe_drain_in)                                     state_d = ST_OS_DRAIN;
                else if (!pe_valid_in && !acc_pending_q && !mode_os) state_d = ST_WS;
            end
            ST_OS_DRAIN: state_d = ST_OS_ACC;
            default:     state_d = ST_WS;
        endcase
    end

    always_comb begin
        acc_d         = acc_q;
        acc_pending_d = acc_pending_q;
        w_active_d    = w_active_q;
        w_inactive_d  = w_inactive_q;
        psum_d        = '0;
        psum_valid_d  = 1'b0;
        if (!is_os) begin
            if (pe_valid_in) begin
                psum_d       = sum_r[DATA_WIDTH-1:0];
                psum_valid_d = 1'b1;
            end
            if (pe_accept_w_in) w_inactive_d = $signed(pe_weight_in);
            if (pe_switch_in)   w_active_d   = w_inactive_q;
        end else if (pe_drain_in) begin
            psum_d        = do_mac ? sum_r[DATA_WIDTH-1:0] : acc_q;
            psum_valid_d  = 1'b1;
            acc_d         = '0;
            acc_pending_d = 1'b0;
        end else if (do_mac) begin
            acc_d         = $signed(sum_r[DATA_WIDTH-1:0]);
            acc_pending_d = 1'b1;
        end

        weight_fwd_d = pe_accept_w_in ? pe_weight_in : '0;
        accept_fwd_d = pe_accept_w_in;
        input_fwd_d  = pe_valid_in ? pe_input_in : '0;
        valid_fwd_d  = pe_valid_in;
        switch_fwd_d = pe_switch_in;
        drain_fwd_d  = pe_drain_in;
`ifdef PE_SATURATE_EN
        ovf_d = sat_evt | (ovf_q & ~clear_ovf);
`else
        ovf_d = 1'b0;
`endif
    end

`ifndef PE_SATURATE_EN
    logic unused_ovf_inputs;
    assign unused_ovf_inputs = clear_ovf ^ sat_evt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_WS;
            acc_q         <= '0;
            acc_pending_q <= 1'b0;
            w_active_q    <= '0;
            w_inactive_q  <= '0;
            psum_q        <= '0;
            psum_valid_q  <= 1'b0;
            weight_fwd_q  <= '0;
            accept_fwd_q  <= 1'b0;
            input_fwd_q   <= '0;
            valid_fwd_q   <= 1'b0;
            switch_fwd_q  <= 1'b0;
            drain_fwd_q   <= 1'b0;
            ovf_q         <= 1'b0;
        end else if (pe_enabled) begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            acc_pending_q <= acc_pending_d;
            w_active_q    <= w_active_d;
            w_inactive_q  <= w_inactive_d;
            psum_q        <= psum_d;
            psum_valid_q  <= psum_valid_d;
            weight_fwd_q  <= weight_fwd_d;
            accept_fwd_q  <= accept_fwd_d;
            input_fwd_q   <= input_fwd_d;
            valid_fwd_q   <= valid_fwd_d;
            switch_fwd_q  <= switch_fwd_d;
            drain_fwd_q   <= drain_fwd_d;
            ovf_q         <= ovf_d;
        end
    end

    assign pe_psum_out       = psum_q;
    assign pe_psum_valid_out = psum_valid_q;
    assign pe_weight_out     = weight_fwd_q;
    assign pe_accept_w_out   = accept_fwd_q;
    assign pe_input_out      = input_fwd_q;
    assign pe_valid_out      = valid_fwd_q;
    assign pe_switch_out     = switch_fwd_q;
    assign pe_drain_out      = drain_fwd_q;
    assign overflow_out      = ovf_q;

endmodule

// File: tb/tb_pe_param.sv
// Bench for pe_param (Q8.8, DATA_WIDTH=16): directed vector table, hand sequences, randomized model comparison.
// Expectations follow PE_SATURATE_EN exactly as the design build does.
module tb_pe_param;

    localparam int DW = 16;
    localparam int FB = 8;
`ifdef PE_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          pe_enabled, mode_os;
    logic [DW-1:0] pe_psum_in, pe_weight_in, pe_input_in;
    logic          pe_accept_w_in, pe_valid_in, pe_switch_in, pe_drain_in, clear_ovf;
    logic [DW-1:0] pe_psum_out, pe_weight_out, pe_input_out;
    logic          pe_psum_valid_out, pe_accept_w_out, pe_valid_out, pe_switch_out, pe_drain_out;
    logic          overflow_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pe_param #(.DATA_WIDTH(DW), .FRAC_BITS(FB)) dut (
        .clk(clk), .rst(rst), .pe_enabled(pe_enabled), .mode_os(mode_os),
        .pe_psum_in(pe_psum_in), .pe_weight_in(pe_weight_in), .pe_accept_w_in(pe_accept_w_in),
        .pe_input_in(pe_input_in), .pe_valid_in(pe_valid_in), .pe_switch_in(pe_switch_in),
        .pe_drain_in(pe_drain_in), .clear_ovf(clear_ovf),
        .pe_psum_out(pe_psum_out), .pe_psum_valid_out(pe_psum_valid_out),
        .pe_weight_out(pe_weight_out), .pe_accept_w_out(pe_accept_w_out),
        .pe_input_out(pe_input_out), .pe_valid_out(pe_valid_out),
        .pe_switch_out(pe_switch_out), .pe_drain_out(pe_drain_out),
        .overflow_out(overflow_out)
    );

    // ---------------- reference model (integer arithmetic) ----------------
    bit      m_os, m_drained, m_pend, m_ovf, m_flag;
    longint  m_acc, m_wa, m_wi;
    logic [DW-1:0] e_psum, e_wout, e_in;
    bit      e_pv, e_aw, e_v, e_sw, e_dr;

    function automatic longint to_s(logic [DW-1:0] x);
        return longint'($signed(x));
    endfunction

    function automatic longint floor_div(longint p);
        longint q;
        q = p / (longint'(1) << FB);
        if (p < 0 && q * (longint'(1) << FB) != p) q = q - 1;
        return q;
    endfunction

    function automatic longint fit(longint x);
        longint m;
        m = x % 65536;
        if (m < 0) m = m + 65536;
        if (m >= 32768) m = m - 65536;
        if (SAT) begin
            m = x;
            if (x > 32767)  begin m = 32767;  m_flag = 1'b1; end
            if (x < -32768) begin m = -32768; m_flag = 1'b1; end
        end
        return m;
    endfunction

    function automatic longint mac(longint addend, longint a, longint b);
        return fit(addend + fit(floor_div(a * b)));
    endfunction

    task automatic model_reset();
        m_os = 0; m_drained = 0; m_pend = 0; m_ovf = 0;
        m_acc = 0; m_wa = 0; m_wi = 0;
        e_psum = '0; e_wout = '0; e_in = '0;
        e_pv = 0; e_aw = 0; e_v = 0; e_sw = 0; e_dr = 0;
    endtask

    task automatic model_step();
        longint r;
        bit     used, old_pend;
        if (!pe_enabled) return;
        old_pend = m_pend;
        m_flag   = 1'b0;
        if (!m_os) begin
            r      = mac(to_s(pe_psum_in), to_s(pe_input_in), pe_switch_in ? m_wi : m_wa);
            used   = pe_valid_in;
            e_psum = pe_valid_in ? 16'(r) : 16'h0;
            e_pv   = pe_valid_in;
            if (pe_switch_in)   m_wa = m_wi;
            if (pe_accept_w_in) m_wi = to_s(pe_weight_in);
        end else begin
            r    = mac(m_acc, to_s(pe_input_in), to_s(pe_weight_in));
            used = pe_valid_in && pe_accept_w_in;
            if (pe_drain_in) begin
                e_psum = 16'(used ? r : m_acc);
                e_pv   = 1; m_acc = 0; m_pend = 0;
            end else begin
                e_psum = '0; e_pv = 0;
                if (used) begin m_acc = r; m_pend = 1; end
            end
        end
        m_ovf = SAT && ((used && m_flag) || (m_ovf && !clear_ovf));
        e_wout = pe_accept_w_in ? pe_weight_in : '0;
        e_aw   = pe_accept_w_in;
        e_in   = pe_valid_in ? pe_input_in : '0;
        e_v    = pe_valid_in;
        e_sw   = pe_switch_in;
        e_dr   = pe_drain_in;
        if (m_drained)               m_drained = 0;
        else if (m_os && pe_drain_in) m_drained = 1;
        else if (!pe_valid_in && !old_pend) m_os = mode_os;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [53:0] dut_vec();
        return {pe_psum_out, pe_psum_valid_out, pe_weight_out, pe_accept_w_out,
                pe_input_out, pe_valid_out, pe_switch_out, pe_drain_out, overflow_out};
    endfunction

    function automatic logic [53:0] model_vec();
        return {e_psum, e_pv, e_wout, e_aw, e_in, e_v, e_sw, e_dr, m_ovf};
    endfunction

    task automatic idle();
        pe_accept_w_in = 0; pe_valid_in = 0; pe_switch_in = 0; pe_drain_in = 0;
        clear_ovf = 0; pe_enabled = 1;
        pe_psum_in = '0; pe_weight_in = '0; pe_input_in = '0;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic os_mac(input logic [DW-1:0] a, input logic [DW-1:0] w);
        idle(); pe_valid_in = 1; pe_accept_w_in = 1; pe_input_in = a; pe_weight_in = w;
    endtask

    typedef struct {
        logic [DW-1:0] w;
        logic [DW-1:0] in;
        logic [DW-1:0] ps;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t tbl[7];

    initial begin
        tbl[0] = '{16'h0200, 16'h0180, 16'h0100, 16'h0400};
        tbl[1] = '{16'hFF00, 16'h0300, 16'h0000, 16'hFD00};
        tbl[2] = '{16'h0080, 16'hFFFF, 16'h0000, 16'hFFFF};
        tbl[3] = '{16'h0100, 16'h1234, 16'h0001, 16'h1235};
        tbl[4] = '{16'hFE00, 16'hFF00, 16'hFF00, 16'h0100};
        tbl[5] = '{16'h0001, 16'h0001, 16'h0005, 16'h0005};
        tbl[6] = '{16'h0000, 16'h7FFF, 16'h8000, 16'h8000};

        rst = 1; mode_os = 0; idle();
        model_reset();
        #12;
        chk("reset_outputs", 32'(dut_vec() != 54'd0), 32'd0);
        rst = 0;
        @(posedge clk); #1;

        // WS: load, then switch + valid in the same cycle (MAC bypasses to the new weight)
        for (int i = 0; i < 7; i++) begin
            idle(); pe_accept_w_in = 1; pe_weight_in = tbl[i].w;
            cycle();
            idle(); pe_switch_in = 1; pe_valid_in = 1;
            pe_input_in = tbl[i].in; pe_psum_in = tbl[i].ps;
            cycle();
            chk($sformatf("ws_tbl%0d_psum", i), pe_psum_out, tbl[i].exp);
            chk($sformatf("ws_tbl%0d_valid", i), pe_psum_valid_out, 1);
            chk($sformatf("ws_tbl%0d_switch_out", i), pe_switch_out, 1);
        end

        // back-to-back weight swap
        idle(); pe_accept_w_in = 1; pe_weight_in = 16'h0200; cycle();
        idle(); pe_switch_in = 1; cycle();
        idle(); pe_accept_w_in = 1; pe_weight_in = 16'h0100; pe_valid_in = 1; pe_input_in = 16'h0100;
        cycle();
        chk("b2b_old_weight", pe_psum_out, 16'h0200);
        chk("b2b_weight_fwd", {pe_accept_w_out, pe_weight_out}, {1'b1, 16'h0100});
        idle(); pe_switch_in = 1; pe_valid_in = 1; pe_input_in = 16'h0100; cycle();
        chk("b2b_switch_cycle", pe_psum_out, 16'h0100);
        idle(); pe_valid_in = 1; pe_input_in = 16'h0100; cycle();
        chk("b2b_after_switch", pe_psum_out, 16'h0100);

        // load and switch together promote the previously loaded weight
        idle(); pe_accept_w_in = 1; pe_weight_in = 16'h0300; pe_input_in = 16'h0100; cycle();
        chk("ws_invalid_psum", {pe_psum_valid_out, pe_psum_out}, 17'h0);
        chk("fwd_input_zeroed", {pe_valid_out, pe_input_out}, 17'h0);
        idle(); pe_accept_w_in = 1; pe_weight_in = 16'h0400; pe_switch_in = 1;
        pe_valid_in = 1; pe_input_in = 16'h0100; cycle();
        chk("load_switch_uses_old", pe_psum_out, 16'h0300);
        idle(); pe_switch_in = 1; pe_valid_in = 1; pe_input_in = 16'h0100; cycle();
        chk("load_switch_next", pe_psum_out, 16'h0400);

        // OS accumulate and drain
        idle(); mode_os = 1; cycle();
        for (int i = 0; i < 3; i++) begin
            os_mac(16'h0100, 16'h0080); cycle();
            chk($sformatf("os_acc%0d_novalid", i), pe_psum_valid_out, 0);
        end
        idle(); pe_drain_in = 1; cycle();
        chk("os_drain1", {pe_psum_valid_out, pe_psum_out}, {1'b1, 16'h0180});
        chk("os_drain_fwd", pe_drain_out, 1);
        idle(); cycle();
        chk("os_after_drain", pe_psum_valid_out, 0);
        idle(); pe_drain_in = 1; cycle();
        chk("os_drain2_empty", {pe_psum_valid_out, pe_psum_out}, {1'b1, 16'h0000});
        idle(); cycle();
        os_mac(16'h0200, 16'h0100); pe_drain_in = 1; cycle();
        chk("os_drain_with_mac", {pe_psum_valid_out, pe_psum_out}, {1'b1, 16'h0200});

        // stall mid-accumulation
        idle(); cycle();
        os_mac(16'h0100, 16'h0100); cycle();
        for (int i = 0; i < 3; i++) begin
            os_mac(16'h7777, 16'h0100); pe_drain_in = 1; pe_enabled = 0; cycle();
            chk($sformatf("stall%0d_frozen", i),
                {pe_psum_valid_out, pe_psum_out, pe_valid_out, pe_input_out, pe_drain_out},
                {1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0});
        end
        os_mac(16'h0100, 16'h0100); cycle();
        idle(); pe_drain_in = 1; cycle();
        chk("stall_resume_sum", {pe_psum_valid_out, pe_psum_out}, {1'b1, 16'h0200});

        // saturation / wrap, sticky overflow
        mode_os = 0; idle(); cycle(); cycle();
        idle(); pe_accept_w_in = 1; pe_weight_in = 16'h0200; cycle();
        idle(); pe_switch_in = 1; pe_valid_in = 1; pe_input_in = 16'h7F00; cycle();
        chk("sat_pos_psum", pe_psum_out, SAT ? 16'h7FFF : 16'hFE00);
        chk("sat_pos_ovf", overflow_out, SAT);
        idle(); cycle();
        chk("ovf_sticky", overflow_out, SAT);
        idle(); pe_valid_in = 1; pe_input_in = 16'h7F00; clear_ovf = 1; cycle();
        chk("ovf_set_wins", overflow_out, SAT);
        idle(); clear_ovf = 1; cycle();
        chk("ovf_cleared", overflow_out, 0);
        idle(); pe_valid_in = 1; pe_input_in = 16'h8100; cycle();
        chk("sat_neg_psum", pe_psum_out, SAT ? 16'h8000 : 16'h0200);
        chk("sat_neg_ovf", overflow_out, SAT);
        idle(); clear_ovf = 1; cycle();
        idle(); pe_valid_in = 1; pe_input_in = 16'h0800; pe_psum_in = 16'h7000; cycle();
        chk("sat_sum_psum", pe_psum_out, SAT ? 16'h7FFF : 16'h8000);
        chk("sat_sum_ovf", overflow_out, SAT);

        // asynchronous reset during accumulation
        idle(); mode_os = 1; cycle();
        os_mac(16'h0100, 16'h0100); cycle();
        os_mac(16'h0100, 16'h0300); pe_switch_in = 1; cycle();
        #3 rst = 1;
        #1;
        chk("async_rst_outputs", 32'(dut_vec() != 54'd0), 32'd0);
        mode_os = 0; idle(); model_reset();
        #1 rst = 0;
        pe_valid_in = 1; pe_input_in = 16'h0100; pe_psum_in = 16'h0123; cycle();
        chk("rst_state_ws", {pe_psum_valid_out, pe_psum_out}, {1'b1, 16'h0123});
        idle(); mode_os = 1; cycle();
        idle(); pe_drain_in = 1; cycle();
        chk("rst_acc_discarded", {pe_psum_valid_out, pe_psum_out}, {1'b1, 16'h0000});

        // randomized run against the model
        idle(); mode_os = 0;
        rst = 1; #2 rst = 0;
        model_reset();
        @(posedge clk); #1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(19) == 0) mode_os = ~mode_os;
            pe_enabled     = ($urandom_range(9) != 0);
            pe_valid_in    = ($urandom_range(9) < 6);
            pe_accept_w_in = ($urandom_range(1) == 1);
            pe_switch_in   = ($urandom_range(6) == 0);
            pe_drain_in    = ($urandom_range(9) == 0);
            clear_ovf      = ($urandom_range(19) == 0);
            pe_psum_in     = 16'($urandom);
            pe_weight_in   = ($urandom_range(1) == 1) ? 16'($urandom) : 16'($urandom_range(1023));
            pe_input_in    = ($urandom_range(1) == 1) ? 16'($urandom) : 16'($urandom_range(1023));
            cycle();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL rand[%0d]: got %h, want %h", c, dut_vec(), model_vec());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pe_param.md
# pe_param

Parametrised weight-stationary / output-stationary processing element for the systolic array, and the next generation of the 16-bit PE tile. It adds:
- generic data width and fixed-point format;
- a registered (not combinational) double-buffered weight swap;
- an output-stationary accumulate/drain mode;
- stall-on-disable;
- optional saturating arithmetic with a sticky overflow flag.

It tiles in the same N/S/E/W mesh as the existing PE.

## Interface
Parameters:
- DATA_WIDTH, 16, signed two's-complement width of all data paths.
- FRAC_BITS, 8, fractional bits of the Q format (0 ≤ FRAC_BITS < DATA_WIDTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pe_enabled  in  1  1 = run; 0 = stall, all registers hold.
- mode_os  in  1  0 = weight-stationary (WS), 1 = output-stationary (OS).
- pe_psum_in  in  DATA_WIDTH  north partial sum (WS only).
- pe_weight_in  in  DATA_WIDTH  north weight.
- pe_accept_w_in  in  1  weight-load strobe (WS) / weight-valid (OS).
- pe_input_in  in  DATA_WIDTH  west activation.
- pe_valid_in  in  1  activation valid.
- pe_switch_in  in  1  WS: promote inactive weight to active.
- pe_drain_in  in  1  OS: emit and clear accumulator.
- clear_ovf  in  1  clears sticky overflow.
- pe_psum_out  out  DATA_WIDTH  south partial sum / drained accumulator.
- pe_psum_valid_out  out  1  pe_psum_out is meaningful.
- pe_weight_out, pe_accept_w_out  out  DATA_WIDTH, 1  south weight forward.
- pe_input_out, pe_valid_out, pe_switch_out, pe_drain_out  out  DATA_WIDTH, 1, 1, 1  east forward.
- overflow_out  out  1  sticky overflow flag.

## Operation
- MAC arithmetic:
  - prod = in × w, at 2·DATA_WIDTH bits.
  - Arithmetic right shift by FRAC_BITS (truncate toward −inf).
  - Add to addend at DATA_WIDTH+1 bits, then reduce to DATA_WIDTH (see Configuration).
- Weights: w_inactive and w_active registers.
  - accept_w_in=1 (WS): w_inactive ← weight_in.
  - switch_in=1: w_active ← w_inactive at the edge.
  - In the switch cycle the MAC uses w_inactive (bypass), so activations may enter on the switch cycle.
  - Load and switch in the same cycle: the new w_inactive is written, the old w_inactive is promoted and used.
- State machine: WS, OS_ACC, OS_DRAIN.
  - mode_os is sampled only when in WS or OS_ACC with valid_in=0 and acc_pending=0; otherwise the mode change is ignored until that condition holds.
  - OS_ACC → OS_DRAIN on drain_in.
  - OS_DRAIN → OS_ACC unconditionally after 1 cycle.
- WS mode:
  - valid_in=1: psum_out ← psum_in + in·w, psum_valid_out ← 1.
  - valid_in=0: psum_out ← 0, psum_valid_out ← 0.
- OS mode:
  - valid_in & accept_w_in: acc ← acc + in·weight_in; acc_pending ← 1.
  - drain_in: psum_out ← acc (including the same-cycle MAC if any), psum_valid_out ← 1, acc ← 0, acc_pending ← 0.
  - Otherwise psum_valid_out ← 0.
- Forwarding (both modes): east/south outputs register their inputs every enabled cycle. Data outputs whose strobe is low forward 0.
- Overflow: overflow_out is set on any saturation event and cleared only by rst or clear_ovf. If set and clear occur in the same cycle, set wins.

## Timing
- All outputs are registered, with 1-cycle latency from the inputs.
- Reset: every output, acc, both weight registers, overflow_out and state go to 0/WS immediately (asynchronously).
- pe_enabled=0: nothing updates, outputs hold their last values, and drain/switch requests in that cycle are lost. The array controller must not issue them while disabled.
- Reset mid-accumulation discards acc with no drain.
- Drain and valid together: the MAC result is included in the drained value.

## Configuration
- PE_SATURATE_EN defined:
  - The DATA_WIDTH+1 sum and the shifted product clamp to [−2^(DW−1), 2^(DW−1)−1].
  - Any clamp sets overflow_out.
- PE_SATURATE_EN undefined:
  - Two's-complement wrap on the low DATA_WIDTH bits.
  - overflow_out tied to 0; clear_ovf ignored.

## Test plan
Q8.8, DATA_WIDTH=16:
1. WS: load w=0x0200 (2.0), switch and valid in the same cycle, in=0x0180 (1.5), psum_in=0x0100 → next cycle psum_out=0x0400, psum_valid_out=1, switch_out=1.
2. Back-to-back: load 0x0100 while the active weight is 0x0200, then switch → the MAC uses 0x0200 until the switch cycle and 0x0100 from then on.
3. OS: three cycles of in=0x0100 with weight_in=0x0080, then drain → psum_out=0x0180 once; acc=0; the next drain gives 0x0000.
4. Saturation (PE_SATURATE_EN): in=0x7F00, w=0x0200, psum_in=0 → psum_out=0x7FFF, overflow_out=1 and sticky until clear_ovf. Without the macro → wrapped 0xFE00, overflow_out=0.
5. Stall: pe_enabled=0 for 3 cycles mid-OS → outputs frozen; resuming yields an identical sum.
6. Async rst asserted mid-cycle during OS_ACC → all outputs 0 before the next edge; state WS.
